// File: rtl/ifu_pkg.sv
// ifu_pkg: shared FSM encoding and constants for the instruction-fetch stage
package ifu_pkg;
  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;
  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/ifu_skid_buf.sv
// ifu_skid_buf: single-entry {pc, inst} holding register with load, unload and flush
module ifu_skid_buf
  import ifu_pkg::*;
#(
  parameter int PC_WIDTH = 64,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  unload,
  input  logic                  flush,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic [INST_WIDTH-1:0] in_inst,
  output logic                  valid,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [INST_WIDTH-1:0] out_inst
);
  logic                  valid_q, valid_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  always_comb begin
    valid_d = !flush & (load | (valid_q & !unload));
    pc_d = load ? in_pc : pc_q;
    inst_d = load ? in_inst : inst_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q <= '0;
      inst_q <= INST_WIDTH'(INST_NOP);
    end else begin
      valid_q <= valid_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
    end
  end
  assign valid = valid_q;
  assign out_pc = pc_q;
  assign out_inst = inst_q;
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: fetch PC, one-outstanding imem request FSM, skid entry and IF/ID register
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int PC_WIDTH = 64,
  parameter int INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_from_id,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  imem_req_valid,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_data,
  output logic                  id_valid,
  output logic [PC_WIDTH-1:0]   id_pc,
  output logic [INST_WIDTH-1:0] id_inst
);
  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  drop_q, drop_d;
  logic                  id_valid_q, id_valid_d;
  logic [PC_WIDTH-1:0]   id_pc_q, id_pc_d;
  logic [INST_WIDTH-1:0] id_inst_q, id_inst_d;
  logic                  consume, resp, discard, load_resp, load_skid, unload, hs;
  logic                  skid_valid;
  logic [PC_WIDTH-1:0]   skid_pc;
  logic [INST_WIDTH-1:0] skid_inst;
  always_comb begin
    consume = id_valid_q & !stall_from_id;
    resp = (state_q == WAIT) & imem_resp_valid;
    discard = resp & (drop_q | redirect_valid);
    load_resp = resp & !discard & (!id_valid_q | consume);
    load_skid = resp & !discard & id_valid_q & !consume;
    unload = (state_q == HOLD) & skid_valid & consume & !redirect_valid;
    imem_req_valid = (state_q == REQ) & !redirect_valid;
    imem_req_addr = pc_q;
    hs = imem_req_valid & imem_req_ready;
    pc_d = redirect_valid ? redirect_pc : hs ? pc_q + PC_WIDTH'(PC_STEP) : pc_q;
    drop_d = (state_q == WAIT) & !resp & (redirect_valid | drop_q);
    state_d = (state_q == REQ)  ? (hs ? WAIT : REQ) :
              (state_q == WAIT) ? (!resp ? WAIT : (discard | load_resp) ? REQ : HOLD) :
              (redirect_valid | unload) ? REQ : HOLD;
    id_valid_d = !redirect_valid & (load_resp | unload | (id_valid_q & !consume));
    id_pc_d = load_resp ? pc_q - PC_WIDTH'(PC_STEP) : unload ? skid_pc : id_pc_q;
    id_inst_d = load_resp ? imem_resp_data : unload ? skid_inst : id_inst_q;
  end
  ifu_skid_buf #(.PC_WIDTH(PC_WIDTH), .INST_WIDTH(INST_WIDTH)) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .load(load_skid),
    .unload(unload),
    .flush(redirect_valid),
    .in_pc(pc_q - PC_WIDTH'(PC_STEP)),
    .in_inst(imem_resp_data),
    .valid(skid_valid),
    .out_pc(skid_pc),
    .out_inst(skid_inst)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q <= RESET_PC;
      drop_q <= 1'b0;
      id_valid_q <= 1'b0;
      id_pc_q <= '0;
      id_inst_q <= INST_WIDTH'(INST_NOP);
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      drop_q <= drop_d;
      id_valid_q <= id_valid_d;
      id_pc_q <= id_pc_d;
      id_inst_q <= id_inst_d;
    end
  end
  assign id_valid = id_valid_q;
  assign id_pc = id_pc_q;
  assign id_inst = id_inst_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed scenario tasks with a fetch scoreboard for ifu_fetch
module tb_ifu_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_from_id = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
  typedef struct packed {logic [63:0] pc; logic [31:0] inst;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  ifu_fetch dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall_from_id(stall_from_id),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .id_valid(id_valid),
    .id_pc(id_pc),
    .id_inst(id_inst)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic exp_t pop_exp();
    exp_t r;
    r = 'x;
    if (exp_q.size() != 0) r = exp_q.pop_front();
    return r;
  endfunction
  task automatic test_reset();
    step();
    step();
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%h exp=0", id_valid); end
    checks++; if (id_pc !== 64'h0) begin failures++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
    checks++; if (id_inst !== 32'h0000_0013) begin failures++; $display("FAIL reset_id_inst got=%h exp=00000013", id_inst); end
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL reset_req_valid got=%h exp=1", imem_req_valid); end
    checks++; if (imem_req_addr !== 64'h8000_0000) begin failures++; $display("FAIL reset_req_addr got=%h exp=80000000", imem_req_addr); end
  endtask
  task automatic test_basic();
    imem_req_ready = 1'b1;
    exp_q.push_back('{64'h8000_0000, 32'h0000_0093});
    step();
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL basic_wait_valid got=%h exp=0", imem_req_valid); end
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0000_0093;
    step();
    imem_resp_valid = 1'b0;
    e = pop_exp();
    checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL basic_id_valid got=%h exp=1", id_valid); end
    checks++; if (id_pc !== e.pc || id_inst !== e.inst) begin failures++; $display("FAIL basic_id got=%h/%h exp=%h/%h", id_pc, id_inst, e.pc, e.inst); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004) begin failures++; $display("FAIL basic_next_req got=%h/%h exp=1/80000004", imem_req_valid, imem_req_addr); end
  endtask
  task automatic test_stall_skid();
    stall_from_id = 1'b1;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0010_0113;
    exp_q.push_back('{64'h8000_0004, 32'h0010_0113});
    step();
    imem_resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'h8000_0000) begin failures++; $display("FAIL stall_hold_id[%0d] got=%h/%h exp=1/80000000", i, id_valid, id_pc); end
      checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_no_req[%0d] got=%h exp=0", i, imem_req_valid); end
      if (i == 0) step();
    end
    stall_from_id = 1'b0;
    step();
    e = pop_exp();
    checks++; if (id_valid !== 1'b1 || id_pc !== e.pc || id_inst !== e.inst) begin failures++; $display("FAIL stall_skid_unload got=%h/%h/%h exp=1/%h/%h", id_valid, id_pc, id_inst, e.pc, e.inst); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0008) begin failures++; $display("FAIL stall_next_req got=%h/%h exp=1/80000008", imem_req_valid, imem_req_addr); end
  endtask
  task automatic test_redirect_wait();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0100;
    step();
    redirect_valid = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hdead_beef;
    step();
    imem_resp_valid = 1'b0;
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL redir_wait_id_valid got=%h exp=0", id_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100) begin failures++; $display("FAIL redir_wait_req got=%h/%h exp=1/80000100", imem_req_valid, imem_req_addr); end
  endtask
  task automatic test_redirect_resp_stalled();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0020_0193;
    exp_q.push_back('{64'h8000_0100, 32'h0020_0193});
    step();
    imem_resp_valid = 1'b0;
    e = pop_exp();
    checks++; if (id_valid !== 1'b1 || id_pc !== e.pc || id_inst !== e.inst) begin failures++; $display("FAIL rrs_load got=%h/%h/%h exp=1/%h/%h", id_valid, id_pc, id_inst, e.pc, e.inst); end
    stall_from_id = 1'b1;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hbad0_0bad;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0200;
    step();
    imem_resp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rrs_id_valid got=%h exp=0", id_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0200) begin failures++; $display("FAIL rrs_req got=%h/%h exp=1/80000200", imem_req_valid, imem_req_addr); end
    stall_from_id = 1'b0;
    step();
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rrs_skid_empty got=%h exp=0", id_valid); end
  endtask
  task automatic test_ready_low();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0200) begin failures++; $display("FAIL ready_low[%0d] got=%h/%h exp=1/80000200", i, imem_req_valid, imem_req_addr); end
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL ready_low_hs got=%h exp=0", imem_req_valid); end
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0030_0213;
    exp_q.push_back('{64'h8000_0200, 32'h0030_0213});
    step();
    imem_resp_valid = 1'b0;
    e = pop_exp();
    checks++; if (id_valid !== 1'b1 || id_pc !== e.pc || id_inst !== e.inst) begin failures++; $display("FAIL ready_low_load got=%h/%h/%h exp=1/%h/%h", id_valid, id_pc, id_inst, e.pc, e.inst); end
    checks++; if (imem_req_addr !== 64'h8000_0204) begin failures++; $display("FAIL ready_low_next got=%h exp=80000204", imem_req_addr); end
  endtask
  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    imem_req_ready = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL wrap_redir_ready_valid got=%h exp=0", imem_req_valid); end
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_req got=%h/%h exp=1/fffffffffffffffc", imem_req_valid, imem_req_addr); end
    step();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0040_0293;
    exp_q.push_back('{64'hFFFF_FFFF_FFFF_FFFC, 32'h0040_0293});
    step();
    imem_resp_valid = 1'b0;
    e = pop_exp();
    checks++; if (id_valid !== 1'b1 || id_pc !== e.pc || id_inst !== e.inst) begin failures++; $display("FAIL wrap_load got=%h/%h/%h exp=1/%h/%h", id_valid, id_pc, id_inst, e.pc, e.inst); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin failures++; $display("FAIL wrap_next got=%h/%h exp=1/0", imem_req_valid, imem_req_addr); end
  endtask
  task automatic test_reset_mid_wait();
    stall_from_id = 1'b1;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0 || id_pc !== 64'h0 || id_inst !== 32'h0000_0013) begin failures++; $display("FAIL rst_mid_id got=%h/%h/%h exp=0/0/00000013", id_valid, id_pc, id_inst); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin failures++; $display("FAIL rst_mid_req got=%h/%h exp=1/80000000", imem_req_valid, imem_req_addr); end
    step();
    rst_n = 1'b1;
    stall_from_id = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h1111_1111;
    step();
    imem_resp_valid = 1'b0;
    checks++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin failures++; $display("FAIL rst_late_resp got=%h/%h/%h exp=0/1/80000000", id_valid, imem_req_valid, imem_req_addr); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      imem_req_ready = 1'b1;
      checks++; if (imem_req_addr !== 64'h8000_0000 + 64'(4 * i)) begin failures++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", i, imem_req_addr, 64'h8000_0000 + 64'(4 * i)); end
      step();
      imem_req_ready = 1'b0;
      d = $urandom;
      imem_resp_valid = 1'b1;
      imem_resp_data = d;
      exp_q.push_back('{64'h8000_0000 + 64'(4 * i), d});
      step();
      imem_resp_valid = 1'b0;
      e = pop_exp();
      checks++; if (id_valid !== 1'b1 || id_pc !== e.pc || id_inst !== e.inst) begin failures++; $display("FAIL b2b_load[%0d] got=%h/%h/%h exp=1/%h/%h", i, id_valid, id_pc, id_inst, e.pc, e.inst); end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_stall_skid();
    test_redirect_wait();
    test_redirect_resp_stalled();
    test_ready_low();
    test_wrap();
    test_reset_mid_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
